// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data + odd parity + stop, ACK check.
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       clk_sync_q, clk_sync_d;
    logic [2:0]       data_sync_q, data_sync_d;
    logic [9:0]       frame_q, frame_d;
    logic [3:0]       idx_q, idx_d;
    logic [INH_W-1:0] inh_q, inh_d;
    logic             ok_q, ok_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             fall, lines_idle, timeout;

    assign fall       = clk_sync_q[2] & ~clk_sync_q[1];
    // Two consecutive synced samples of both lines high.
    assign lines_idle = &{clk_sync_q[2:1], data_sync_q[2:1]};

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_run;

    assign wd_run  = (state_q == RTS) || (state_q == SHIFT) || (state_q == ACK);
    assign timeout = wd_run && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wd_d = '0;
        if (wd_run) wd_d = wd_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) wd_q <= '0;
        else      wd_q <= wd_d;
    end
`else
    // No watchdog; the comparison is constant false and only keeps the parameter referenced.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
        data_sync_d = {data_sync_q[1:0], ps2_data};
        state_d     = state_q;
        frame_d     = frame_q;
        idx_d       = idx_q;
        inh_d       = inh_q;
        ok_d        = ok_q;
        clk_oe_d    = clk_oe_q;
        data_oe_d   = data_oe_q;
        ready_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                ready_d   = 1'b1;
                if (tx_valid && ready_q) begin
                    frame_d  = {1'b1, ~^tx_data, tx_data};
                    inh_d    = '0;
                    clk_oe_d = 1'b1;
                    ready_d  = 1'b0;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                    data_oe_d = 1'b1;
                    state_d   = RTS;
                end else begin
                    inh_d = inh_q + 1'b1;
                end
            end
            RTS: begin
                clk_oe_d = 1'b0;
                idx_d    = '0;
                state_d  = SHIFT;
            end
            SHIFT: begin
                if (fall) begin
                    data_oe_d = ~frame_q[idx_q];
                    idx_d     = idx_q + 1'b1;
                    if (idx_q == 4'd9) state_d = ACK;
                end
            end
            ACK: begin
                if (fall) begin
                    ok_d    = ~data_sync_q[1];
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (lines_idle) begin
                    done_d  = ok_q;
                    err_d   = ~ok_q;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            err_d     = 1'b1;
            ready_d   = 1'b1;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            frame_q     <= '0;
            idx_q       <= '0;
            inh_q       <= '0;
            ok_q        <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            frame_q     <= frame_d;
            idx_q       <= idx_d;
            inh_q       <= inh_d;
            ok_q        <= ok_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
        end
    end

    assign tx_ready    = ready_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;
    assign busy        = (state_q != IDLE);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a PS/2 device model clocks frames and captures bits; a scoreboard checks outcomes.
module tb_ps2_tx;
    localparam int INH  = 20;
    localparam int TMO  = 2000;
    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_done, tx_err, busy, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk, ps2_data;
    logic [9:0] bits;

    int   vecs = 0;
    int   errs = 0;
    bit   chk_en = 1'b0;
    logic rst_prev = 1'b0;
    bit   prev_pulse = 1'b0;
    bit   out_q[$];

    // Open-drain lines: low if either side pulls.
    assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data = ~(ps2_data_oe | dev_data_low);

    ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err), .busy(busy),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rst_prev <= rst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Wire order on the bus: data LSB first, then odd parity, then stop=1.
    function automatic logic [9:0] exp_frame(input logic [7:0] b);
        int   ones = 0;
        logic par;
        for (int i = 0; i < 8; i++) if (b[i]) ones++;
        par = ((ones % 2) == 0);
        return {1'b1, par, b};
    endfunction

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        while (!tx_ready && n < 200) begin @(negedge clk); n++; end
        check("accept_wait", n < 200, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        check("ready_drop", {tx_ready, busy}, 2'b01);
    endtask

    task automatic measure_inhibit();
        int g = 0;
        int n = 0;
        while (!ps2_clk_oe && g < 100) begin @(negedge clk); g++; end
        while (!ps2_data_oe && n < INH + 50) begin n++; @(negedge clk); end
        check("inhibit_len", n, INH);
        check("rts_clk_still_low", ps2_clk_oe, 1);
        @(negedge clk);
        check("rts_clk_release", {ps2_clk_oe, ps2_data_oe}, 2'b01);
    endtask

    task automatic dev_frame(input bit ack, input int abort_fall, output logic [9:0] cap);
        int g = 0;
        cap = '0;
        while (!(ps2_clk === 1'b1 && ps2_data === 1'b0) && g < 100) begin @(negedge clk); g++; end
        check("rts_seen", g < 100, 1);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) dev_data_low = ack;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b1;
            if (k == abort_fall) begin
                rst = 1'b0;
                @(negedge clk);
                check("reset_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
                check("reset_flags", {tx_ready, busy, tx_done, tx_err}, 4'b0000);
                @(negedge clk);
                dev_clk_low = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                check("ready_after_reset", tx_ready, 1);
                return;
            end
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k <= 10) cap[k-1] = ps2_data;
        end
        dev_data_low = 1'b0;
        out_q.push_back(ack);
    endtask

    task automatic wait_pulse();
        int n = 0;
        while (!(tx_done || tx_err) && n < 500) begin @(negedge clk); n++; end
        check("pulse_seen", n < 500, 1);
        @(negedge clk);
    endtask

    // Scoreboard and invariants, every cycle once out of the first reset.
    always @(negedge clk) begin
        bit exp_ok;
        if (chk_en) begin
            check("done_err_excl", tx_done & tx_err, 0);
            if (rst_prev) check("busy_vs_ready", busy, !tx_ready);
            if (tx_ready) check("idle_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
            if (tx_done || tx_err) begin
                check("pulse_width", prev_pulse, 0);
                check("pulse_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
                if (out_q.size() == 0) begin
                    check("unexpected_pulse", {tx_done, tx_err}, 2'b00);
                end else begin
                    exp_ok = out_q.pop_front();
                    check("outcome", {tx_done, tx_err}, exp_ok ? 2'b10 : 2'b01);
                end
            end
            prev_pulse = tx_done || tx_err;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_state", {ps2_clk_oe, ps2_data_oe, tx_done, tx_err, busy, tx_ready}, 6'b0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_first", tx_ready, 1);

        // 0xED: 1,0,1,1,0,1,1,1 parity 1 stop 1.
        send(8'hED);
        measure_inhibit();
        dev_frame(1'b1, 0, bits);
        check("frame_ED_model", bits, exp_frame(8'hED));
        check("frame_ED_literal", bits, 10'h3ED);
        wait_pulse();
        check("ready_after_ED", tx_ready, 1);

        // Odd parity: 0xFF (eight ones) and 0x00 (zero ones) both carry parity 1.
        send(8'hFF);
        measure_inhibit();
        dev_frame(1'b1, 0, bits);
        check("frame_FF_literal", bits, 10'h3FF);
        wait_pulse();
        send(8'h00);
        measure_inhibit();
        dev_frame(1'b1, 0, bits);
        check("frame_00_model", bits, exp_frame(8'h00));
        check("frame_00_literal", bits, 10'h300);
        wait_pulse();

        // Missing ACK.
        send(8'h5A);
        measure_inhibit();
        dev_frame(1'b0, 0, bits);
        check("frame_5A_model", bits, exp_frame(8'h5A));
        wait_pulse();
        check("noack_lines", {ps2_clk_oe, ps2_data_oe, tx_ready}, 3'b001);

        // tx_valid held: first byte goes out, 0xF4 only after tx_ready returns.
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h12;
        begin
            int n = 0;
            while (!tx_ready && n < 200) begin @(negedge clk); n++; end
            check("held_accept", n < 200, 1);
        end
        @(negedge clk);
        tx_data = 8'hF4;
        measure_inhibit();
        dev_frame(1'b1, 0, bits);
        check("held_first_frame", bits, exp_frame(8'h12));
        wait_pulse();
        tx_valid = 1'b0;
        check("held_second_started", {busy, ps2_clk_oe}, 2'b11);
        measure_inhibit();
        dev_frame(1'b1, 0, bits);
        check("held_second_frame", bits, exp_frame(8'hF4));
        check("frame_F4_literal", bits, 10'h2F4);
        wait_pulse();
        repeat (5) @(negedge clk);
        check("held_no_third", {tx_ready, busy}, 2'b10);

        // Reset at fall 5, then a clean frame.
        send(8'hED);
        measure_inhibit();
        dev_frame(1'b1, 5, bits);
        send(8'h3C);
        measure_inhibit();
        dev_frame(1'b1, 0, bits);
        check("after_reset_frame", bits, exp_frame(8'h3C));
        wait_pulse();

`ifdef PS2_TX_TIMEOUT_EN
        // Silent device: tx_err TMO cycles after RTS entry.
        send(8'hAA);
        measure_inhibit();
        out_q.push_back(1'b0);
        begin
            int n = 1;
            while (!tx_err && n < TMO + 100) begin @(negedge clk); n++; end
            check("timeout_cycles", n, TMO);
        end
        @(negedge clk);
`endif

        repeat (20) @(negedge clk);
        check("outcomes_drained", out_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
